apa102_frame_engine: RTL

Parameterised APA102-style LED strand transmitter: holds one 29-bit pixel word per LED, and on a start request serialises a complete frame (start word, one LED word per LED, end words) on its own SCK/MOSI pair. A per-LED on/off mask can auto-rotate after each frame, which gives moving patterns such as rain. One instance drives one strand. The top level instantiates one per strand, with NUM_LEDS set to that strand's length.

---
 rtl/apa102_frame_engine_if.sv | 37 +++
 rtl/apa102_frame_engine.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/apa102_frame_engine_if.sv
// apa102_frame_engine_if
//   Bundles the pixel-write, mask, frame-request and strand signals of one
//   APA102 frame engine. The engine uses the slave modport, whatever drives
//   the engine (controller or bench) uses the master modport.
//   wr_en/wr_addr/wr_data : pixel buffer write port (data = {bri5, b8, g8, r8})
//   mask_ld/mask_in       : load the per-LED on/off mask
//   rotate_en             : rotate the mask once after each completed frame
//   start                 : frame request
//   busy/done             : frame in progress / one-cycle completion pulse
//   sck/mosi              : strand clock and data
interface apa102_frame_engine_if #(
  parameter int NUM_LEDS = 12
);
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [28:0]         wr_data;
  logic                mask_ld;
  logic [NUM_LEDS-1:0] mask_in;
  logic                rotate_en;
  logic                start;
  logic                busy;
  logic                done;
  logic                sck;
  logic                mosi;

  modport master (
    output wr_en, wr_addr, wr_data, mask_ld, mask_in, rotate_en, start,
    input  busy, done, sck, mosi
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, mask_ld, mask_in, rotate_en, start,
    output busy, done, sck, mosi
  );
endinterface

// File: rtl/apa102_frame_engine.sv
// apa102_frame_engine
//   Drives one APA102 LED strand. Holds a 29-bit pixel word per LED and, on a
//   start request, shifts out a full frame on sck/mosi: 32 zero bits, one
//   32-bit word per LED (masked-off LEDs get brightness 0), then
//   32*END_WORDS one bits. The on/off mask can rotate after every frame.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : apa102_frame_engine_if slave modport (write port, mask control,
//           start/busy/done handshake, sck/mosi strand pins)
module apa102_frame_engine #(
  parameter int NUM_LEDS = 12,
  parameter int CLK_DIV  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  apa102_frame_engine_if.slave  bus
);
  localparam int AW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int END_WORDS = (NUM_LEDS + 63) / 64;
  localparam int EWB       = $clog2(END_WORDS + 1);
  localparam int WW        = (AW > EWB) ? AW : EWB;
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_START_FR = 2'd1;
  localparam logic [1:0] S_LED_FR   = 2'd2;
  localparam logic [1:0] S_END_FR   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic                sck_q, sck_d;
  logic [4:0]          bit_q, bit_d;
  logic [WW-1:0]       word_q, word_d;
  logic [31:0]         shift_q, shift_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [NUM_LEDS-1:0] frame_mask_q, frame_mask_d;

  logic [28:0]         pix_q [NUM_LEDS];
  logic [AW-1:0]       fetchIdx;
  logic [31:0]         fetchWord;
  logic [NUM_LEDS-1:0] maskRot;
  logic                frameDone;

  // Pixel buffer: plain storage, deliberately left out of reset so a reset
  // mid-show does not blank the colours the controller already loaded.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (int'(bus.wr_addr) < NUM_LEDS)) begin
      pix_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Rotation toward higher LED index; a single LED has nothing to rotate.
  if (NUM_LEDS > 1) begin : g_rot
    assign maskRot = {mask_q[NUM_LEDS-2:0], mask_q[NUM_LEDS-1]};
  end else begin : g_norot
    assign maskRot = mask_q;
  end

  // The next LED word is fetched at the boundary where the previous word
  // finishes: LED 0 at the end of the start word, LED k+1 at the end of LED k.
  always_comb begin
    fetchIdx  = (state_q == S_LED_FR) ? AW'(word_q + 1'b1) : '0;
    fetchWord = frame_mask_q[fetchIdx] ? {3'b111, pix_q[fetchIdx]} : 32'hE000_0000;
  end

  // Frame sequencer: each bit is CLK_DIV cycles low then CLK_DIV cycles high;
  // the shift register advances only on the falling sck edge so mosi is
  // steady across the whole high phase.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    sck_d        = sck_q;
    bit_d        = bit_q;
    word_d       = word_q;
    shift_d      = shift_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    frame_mask_d = frame_mask_q;
    frameDone    = 1'b0;

    if (state_q == S_IDLE) begin
      if (bus.start) begin
        state_d      = S_START_FR;
        busy_d       = 1'b1;
        div_d        = '0;
        sck_d        = 1'b0;
        bit_d        = '0;
        word_d       = '0;
        shift_d      = '0;
        frame_mask_d = mask_q;
      end
    end else if (div_q == DW'(CLK_DIV - 1)) begin
      div_d = '0;
      if (!sck_q) begin
        sck_d = 1'b1;
      end else begin
        sck_d = 1'b0;
        if (bit_q != 5'd31) begin
          bit_d   = bit_q + 1'b1;
          shift_d = {shift_q[30:0], 1'b0};
        end else begin
          bit_d = '0;
          case (state_q)
            S_START_FR: begin
              state_d = S_LED_FR;
              word_d  = '0;
              shift_d = fetchWord;
            end
            S_LED_FR: begin
              if (word_q == WW'(NUM_LEDS - 1)) begin
                state_d = S_END_FR;
                word_d  = '0;
                shift_d = '1;
              end else begin
                word_d  = word_q + 1'b1;
                shift_d = fetchWord;
              end
            end
            S_END_FR: begin
              if (word_q == WW'(END_WORDS - 1)) begin
                state_d   = S_IDLE;
                word_d    = '0;
                shift_d   = '0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                frameDone = 1'b1;
              end else begin
                word_d  = word_q + 1'b1;
                shift_d = '1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Mask register: an explicit load always beats the end-of-frame rotate.
  always_comb begin
    mask_d = mask_q;
    if (bus.mask_ld) begin
      mask_d = bus.mask_in;
    end else if (frameDone && bus.rotate_en) begin
      mask_d = maskRot;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      sck_q        <= 1'b0;
      bit_q        <= '0;
      word_q       <= '0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mask_q       <= '1;
      frame_mask_q <= '1;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      sck_q        <= sck_d;
      bit_q        <= bit_d;
      word_q       <= word_d;
      shift_q      <= shift_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mask_q       <= mask_d;
      frame_mask_q <= frame_mask_d;
    end
  end

  assign bus.sck  = sck_q;
  assign bus.mosi = shift_q[31];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
